// File: rtl/dbus_timer.sv
// dbus_timer: memory-mapped 32-bit timer slave on the core data bus.
//
// Registers (word index = dbus_addr[4:2]):
//   0 CTRL     bit0 en, bit1 auto_reload, bit2 irq_en
//   1 STATUS   bit0 match (sticky, write 1 to clear)
//   2 COUNT    32-bit counter
//   3 COMPARE  32-bit compare value
//   4 PRESCALE bits 15:0 (only with DBUS_TIMER_PRESCALER_EN defined)
//   5..7       read 0, writes ignored
//
// Build option: define DBUS_TIMER_PRESCALER_EN to include the PRESCALE
// register and prescale counter; otherwise COUNT ticks every enabled cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dbus_req/we/be/addr/wdata   request side (inputs)
//   dbus_gnt          = dbus_req, same cycle
//   dbus_rvalid/rdata one-cycle response the cycle after each request
//   irq               level interrupt = match & irq_en
module dbus_timer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbus_req,
    input  logic        dbus_we,
    input  logic [3:0]  dbus_be,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    output logic        dbus_gnt,
    output logic        dbus_rvalid,
    output logic [31:0] dbus_rdata,
    output logic        irq
);

    logic [2:0]  ctrl;      // {irq_en, auto_reload, en}
    logic        match;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    logic [2:0]  idx;
    logic        wr;
    logic [31:0] bmask;
    logic [31:0] rd_val;
    logic        hit;
    logic        sel_count;

    // The arbiter only routes in-window addresses here, so the base and
    // the bits outside addr[4:2] carry no information for decode.
    logic unused_bits;
    assign unused_bits = ^{dbus_addr[31:5], dbus_addr[1:0], BASE_ADDRESS};

    assign dbus_gnt  = dbus_req;
    assign idx       = dbus_addr[4:2];
    assign wr        = dbus_req & dbus_we;
    assign bmask     = {{8{dbus_be[3]}}, {8{dbus_be[2]}}, {8{dbus_be[1]}}, {8{dbus_be[0]}}};
    assign hit       = (count == compare);
    assign sel_count = wr && (idx == 3'd2);
    assign irq       = match & ctrl[2];

`ifdef DBUS_TIMER_PRESCALER_EN
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic        sel_pre;

    assign sel_pre = wr && (idx == 3'd4);
    assign tick    = ctrl[0] && (pcnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (sel_pre) begin
                if (dbus_be[0]) prescale[7:0]  <= dbus_wdata[7:0];
                if (dbus_be[1]) prescale[15:8] <= dbus_wdata[15:8];
                pcnt <= '0;   // restart the period on any PRESCALE write
            end else if (!ctrl[0] || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
        end
    end
`else
    assign tick = ctrl[0];
`endif

    always_comb begin
        rd_val = '0;
        case (idx)
            3'd0: rd_val = {29'b0, ctrl};
            3'd1: rd_val = {31'b0, match};
            3'd2: rd_val = count;
            3'd3: rd_val = compare;
`ifdef DBUS_TIMER_PRESCALER_EN
            3'd4: rd_val = {16'b0, prescale};
`endif
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl        <= '0;
            match       <= 1'b0;
            count       <= '0;
            compare     <= 32'hFFFF_FFFF;
            dbus_rvalid <= 1'b0;
            dbus_rdata  <= '0;
        end else begin
            if (wr && idx == 3'd0 && dbus_be[0])
                ctrl <= dbus_wdata[2:0];

            // A software COUNT write swallows the whole tick, including
            // any match it would have raised. Set beats clear.
            if (tick && hit && !sel_count)
                match <= 1'b1;
            else if (wr && idx == 3'd1 && dbus_be[0] && dbus_wdata[0])
                match <= 1'b0;

            if (sel_count)
                count <= (count & ~bmask) | (dbus_wdata & bmask);
            else if (tick)
                count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

            if (wr && idx == 3'd3)
                compare <= (compare & ~bmask) | (dbus_wdata & bmask);

            // Read data is the pre-update register value; writes answer 0.
            dbus_rvalid <= dbus_req;
            dbus_rdata  <= (dbus_req && !dbus_we) ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_dbus_timer.sv
// tb_dbus_timer: directed plus randomized checks of dbus_timer against a
// cycle-level reference model of the register map and counting rules.
module tb_dbus_timer;

`ifdef DBUS_TIMER_PRESCALER_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, irq;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;

    dbus_timer dut (
        .clk(clk), .rst(rst),
        .dbus_req(req), .dbus_we(we), .dbus_be(be), .dbus_addr(addr),
        .dbus_wdata(wdata), .dbus_gnt(gnt), .dbus_rvalid(rvalid),
        .dbus_rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [2:0]  m_ctrl;
    logic        m_match;
    logic [31:0] m_count, m_cmp;
    logic [15:0] m_pre, m_pcnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mreg(input logic [2:0] a);
        case (a)
            3'd0: return {29'b0, m_ctrl};
            3'd1: return {31'b0, m_match};
            3'd2: return m_count;
            3'd3: return m_cmp;
            3'd4: return PRESC ? {16'b0, m_pre} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_match = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_pre = 0; m_pcnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    // One clock: predict next state from current inputs, clock, compare.
    task automatic step();
        logic        tk, cwr, wr_a;
        logic [2:0]  a;
        logic [2:0]  n_ctrl;
        logic        n_match;
        logic [31:0] n_count, n_cmp, n_rdata;
        logic [15:0] n_pre, n_pcnt;
        logic        n_rvalid;
        a    = addr[4:2];
        wr_a = req && we;
        tk   = m_ctrl[0] && (!PRESC || m_pcnt == m_pre);
        cwr  = wr_a && a == 3'd2;
        n_ctrl = m_ctrl; n_match = m_match; n_count = m_count; n_cmp = m_cmp;
        n_pre = m_pre; n_pcnt = m_pcnt;
        n_rvalid = req;
        n_rdata  = (req && !we) ? mreg(a) : 32'd0;
        if (wr_a && a == 3'd0 && be[0]) n_ctrl = wdata[2:0];
        if (wr_a && a == 3'd1 && be[0] && wdata[0]) n_match = 1'b0;
        if (tk && !cwr && m_count == m_cmp) n_match = 1'b1;
        if (cwr) n_count = merge(m_count, wdata, be);
        else if (tk) n_count = (m_count == m_cmp && m_ctrl[1]) ? 32'd0 : m_count + 1;
        if (wr_a && a == 3'd3) n_cmp = merge(m_cmp, wdata, be);
        if (PRESC) begin
            if (wr_a && a == 3'd4) begin
                n_pre  = merge({16'b0, m_pre}, wdata, {2'b00, be[1:0]}) & 16'hFFFF;
                n_pcnt = 0;
            end else if (!m_ctrl[0] || tk) n_pcnt = 0;
            else n_pcnt = m_pcnt + 1;
        end
        chk("gnt", {31'b0, gnt}, {31'b0, req});
        @(posedge clk); #1;
        if (rst) model_reset();
        else begin
            m_ctrl = n_ctrl; m_match = n_match; m_count = n_count; m_cmp = n_cmp;
            m_pre = n_pre; m_pcnt = n_pcnt; m_rvalid = n_rvalid; m_rdata = n_rdata;
        end
        chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
        chk("rdata", rdata, m_rdata);
        chk("irq", {31'b0, irq}, {31'b0, m_match & m_ctrl[2]});
    endtask

    task automatic idle(input int n);
        req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1; we = 1; be = b; addr = a; wdata = d;
        step();
        req = 0; we = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req = 1; we = 0; be = 0; addr = a; wdata = 0;
        step();
        d = rdata;
        chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
        req = 0;
    endtask

    initial begin
        logic [31:0] d, d2;
        int k;
        rst = 1; req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        model_reset();
        step(); step();
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
        rst = 0;

        // reset values
        rd(32'h00, d); chk("rst_ctrl", d, 32'h0);
        rd(32'h04, d); chk("rst_status", d, 32'h0);
        rd(32'h08, d); chk("rst_count", d, 32'h0);
        rd(32'h0C, d); chk("rst_compare", d, 32'hFFFF_FFFF);
        rd(32'h10, d); chk("rst_prescale", d, 32'h0);

        // match + irq with auto-reload, then clear
        wr(32'h0C, 32'd5, 4'hF);
        wr(32'h00, 32'h7, 4'hF);
        k = 0;
        while (!irq && k < 20) begin idle(1); k++; end
        chk("auto_irq", {31'b0, irq}, 32'd1);
        wr(32'h04, 32'h1, 4'hF);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd(32'h08, d); chk("auto_reload_count", d, 32'd1);

        // prescaler
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h08, 32'h0, 4'hF);
        wr(32'h10, 32'd3, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        rd(32'h08, d);
        idle(7);
        rd(32'h08, d2);
        chk("prescale_rate", d2 - d, PRESC ? 32'd2 : 32'd8);
        rd(32'h10, d); chk("prescale_reg", d, PRESC ? 32'd3 : 32'd0);

        // wrap without match, then match at COMPARE
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h10, 32'h0, 4'hF);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0C, 32'd3, 4'hF);
        wr(32'h04, 32'h1, 4'hF);
        wr(32'h00, 32'h5, 4'hF);
        idle(2);
        chk("wrap_no_match", {31'b0, irq}, 32'd0);
        k = 0;
        while (!irq && k < 10) begin idle(1); k++; end
        chk("wrap_then_match", {31'b0, irq}, 32'd1);
        rd(32'h04, d); chk("wrap_status", d, 32'd1);

        // partial COUNT write beats tick
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h08, 32'h1234_5678, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        idle(3);
        wr(32'h08, 32'h0000_0100, 4'b0001);
        rd(32'h08, d); chk("byte_write_count", d, 32'h1234_5600);

        // match set and clear same cycle: set wins
        wr(32'h00, 32'h0, 4'hF);
        wr(32'h04, 32'h1, 4'hF);
        wr(32'h08, 32'd10, 4'hF);
        wr(32'h0C, 32'd12, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        idle(2);
        wr(32'h04, 32'h1, 4'hF);
        rd(32'h04, d); chk("set_beats_clear", d, 32'd1);

        // back-to-back: read COUNT, write COMPARE, read 0x18
        req = 1; we = 0; addr = 32'h08; be = 0; step();
        chk("b2b_1", {31'b0, rvalid}, 32'd1);
        we = 1; addr = 32'h0C; be = 4'hF; wdata = 32'd99; step();
        chk("b2b_2", {31'b0, rvalid}, 32'd1);
        we = 0; addr = 32'h18; be = 0; step();
        chk("b2b_3", {31'b0, rvalid}, 32'd1);
        chk("b2b_unmapped", rdata, 32'd0);
        // request in the reset cycle gets no response
        addr = 32'h00; rst = 1; step();
        chk("rst_drops_rvalid", {31'b0, rvalid}, 32'd0);
        rst = 0;
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 2) != 0);
            we    = $urandom_range(0, 1);
            addr  = {$urandom_range(0, 7), 2'b00};
            be    = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            wdata = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
            step();
        end
        rst = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
